bp_cce_dir_arbiter: RTL

Sequences and shares the CCE coherence directory (`bp_cce_dir`) between two requesters. Port 0 is the microcode instruction engine; port 1 is the directory sweeper used for invalidate-all and flush. The block grants one directory operation at a time and holds off new issues while a multi-cycle read is in flight. It routes read completion back to the owning requester and, when configured, bounds starvation of port 1.

---
 rtl/bp_cce_pkg.sv | 44 ++++
 rtl/bp_cce_dir_arb_starve.sv | 42 ++++
 rtl/bp_cce_dir_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE directory arbiter: request payload, FSM states and port ids.
package bp_cce_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    // Widths supplied by the default processor configuration.
    localparam int unsigned paddr_width_p     = 40;
    localparam int unsigned lce_id_width_p    = 4;
    localparam int unsigned lce_assoc_width_p = 3;

    typedef enum logic [3:0] {
        e_rdw_op = 4'd0,
        e_rde_op = 4'd1,
        e_wdp_op = 4'd2,
        e_wde_op = 4'd3,
        e_wds_op = 4'd4,
        e_gad_op = 4'd5
    } bp_cce_dir_op_e;

    typedef struct packed {
        logic [paddr_width_p-1:0]     addr;
        logic                         addr_bypass;
        logic [lce_id_width_p-1:0]    lce;
        logic [lce_assoc_width_p-1:0] way;
        logic [lce_assoc_width_p-1:0] lru_way;
        logic [2:0]                   coh_state;
        logic [1:0]                   addr_dst_gpr;
        bp_cce_dir_op_e               cmd;
        logic                         rd;
    } bp_cce_dir_req_s;

    typedef enum logic [0:0] {
        e_idle    = 1'b0,
        e_rd_wait = 1'b1
    } bp_cce_dir_arb_state_e;

    typedef enum logic [0:0] {
        e_dir_port_ucode = 1'b0,
        e_dir_port_sweep = 1'b1
    } bp_cce_dir_port_e;

endpackage

// File: rtl/bp_cce_dir_arb_starve.sv
// Starvation guard for the sweeper port; only instantiated with BP_CCE_DIR_ARB_STARVE_EN.
module bp_cce_dir_arb_starve
    import bp_cce_pkg::*;
#(
    parameter int unsigned starve_limit_p = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic sweep_pending_i,
    input  logic ucode_grant_i,
    input  logic sweep_grant_i,
    output logic clear_o,
    output logic incr_o,
    output logic force_sweep_o
);

    localparam logic [7:0] limit_lp = 8'(starve_limit_p);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        clear_o       = sweep_grant_i || !sweep_pending_i;
        incr_o        = ucode_grant_i && sweep_pending_i && (cnt_q != '1);
        cnt_d         = cnt_q;
        if (clear_o) begin
            cnt_d = '0;
        end else if (incr_o) begin
            cnt_d = cnt_q + 8'd1;
        end
        // Qualified by the live valid so a stale count never blocks port 0.
        force_sweep_o = sweep_pending_i && (cnt_q >= limit_lp);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bp_cce_dir_arbiter.sv
// Shares the CCE directory between the ucode engine (port 0) and the sweeper (port 1).
// Define BP_CCE_DIR_ARB_STARVE_EN to bound starvation of port 1.
module bp_cce_dir_arbiter
    import bp_cce_pkg::*;
#(
    parameter bp_params_e  bp_params_p    = e_bp_default_cfg,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [1:0]            req_v_i,
    input  bp_cce_dir_req_s [1:0] req_i,
    output logic [1:0]            req_ready_o,
    output logic [1:0]            done_v_o,
    output logic                  dir_r_v_o,
    output logic                  dir_w_v_o,
    output bp_cce_dir_req_s       dir_req_o,
    input  logic                  dir_busy_i,
    input  logic                  dir_sharers_v_i
);

    bp_cce_dir_arb_state_e state_q, state_d;
    bp_cce_dir_req_s       payload_q, payload_d;
    bp_cce_dir_port_e      owner_q, owner_d;
    logic [1:0]            wr_done_q, wr_done_d;
    bp_cce_dir_port_e      winner;
    logic                  accept;
    logic                  force_sweep;
    logic                  unused_cfg;

    assign unused_cfg = ^{bp_params_p, 8'(starve_limit_p)};

`ifdef BP_CCE_DIR_ARB_STARVE_EN
    logic unused_starve_clear;
    logic unused_starve_incr;

    bp_cce_dir_arb_starve #(
        .starve_limit_p(starve_limit_p)
    ) starve (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .sweep_pending_i(req_v_i[e_dir_port_sweep]),
        .ucode_grant_i  (accept && (winner == e_dir_port_ucode)),
        .sweep_grant_i  (accept && (winner == e_dir_port_sweep)),
        .clear_o        (unused_starve_clear),
        .incr_o         (unused_starve_incr),
        .force_sweep_o  (force_sweep)
    );
`else
    assign force_sweep = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        owner_d     = owner_q;
        wr_done_d   = '0;
        accept      = 1'b0;
        req_ready_o = '0;
        done_v_o    = reset_i ? 2'b00 : wr_done_q;
        dir_r_v_o   = 1'b0;
        dir_w_v_o   = 1'b0;
        dir_req_o   = payload_q;
        winner      = (force_sweep || !req_v_i[e_dir_port_ucode]) ? e_dir_port_sweep
                                                                  : e_dir_port_ucode;

        unique case (state_q)
            e_idle: begin
                if (!reset_i && !dir_busy_i && req_v_i[winner]) begin
                    accept              = 1'b1;
                    req_ready_o[winner] = 1'b1;
                    dir_req_o           = req_i[winner];
                    if (req_i[winner].rd) begin
                        dir_r_v_o = 1'b1;
                        payload_d = req_i[winner];
                        owner_d   = winner;
                        state_d   = e_rd_wait;
                    end else begin
                        dir_w_v_o         = 1'b1;
                        wr_done_d[winner] = 1'b1;
                    end
                end
            end
            e_rd_wait: begin
                // Completion is reported in the exit cycle itself; no grant until idle.
                if (!reset_i && !dir_busy_i && dir_sharers_v_i) begin
                    done_v_o[owner_q] = 1'b1;
                    state_d           = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= e_idle;
            payload_q <= '0;
            owner_q   <= e_dir_port_ucode;
            wr_done_q <= '0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            owner_q   <= owner_d;
            wr_done_q <= wr_done_d;
        end
    end

endmodule
